// File: rtl/tilt_sin_pkg.sv
// Shared constants and types for the tilt filter and the perspective transform stage.
package tilt_sin_pkg;

  localparam int TILT_IN_W   = 12;
  localparam int SIN_W       = 11;
  localparam int XFORM_CAP   = 60;
  localparam int TILT_LIMIT  = 2 * XFORM_CAP;
  localparam int TILT_AVG_L2 = 3;
  localparam int TILT_DEAD   = 4;
  localparam int TILT_SLEW   = 8;

  typedef logic signed [SIN_W-1:0] sin_t;

  typedef enum logic {
    ACC  = 1'b0,
    CALC = 1'b1
  } tilt_state_t;

endpackage

// File: rtl/tilt_sin_filter_tilt_axis_chan.sv
// One tilt axis: batch accumulator, scale/deadband/clamp into a target, and the
// frame-synchronous output register (slew-limited when TILT_SLEW_EN is defined).
module tilt_axis_chan
  import tilt_sin_pkg::*;
#(
  parameter int IN_W     = TILT_IN_W,
  parameter int OUT_W    = SIN_W,
  parameter int AVG_LOG2 = TILT_AVG_L2,
  parameter int DEAD     = TILT_DEAD,
  parameter int LIMIT    = TILT_LIMIT,
  parameter int SLEW     = TILT_SLEW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  sample,
  input  logic                    accept,
  input  logic                    calc,
  input  logic                    frame_start,
  output logic signed [OUT_W-1:0] sin_out,
  output logic                    changed
);

  localparam int ACC_W = IN_W + AVG_LOG2;
  // Full-scale input (1 g = 2048 counts) lands on half of the output range.
  localparam int SHIFT = IN_W - OUT_W;

  localparam logic signed [ACC_W-1:0] LIM_HI  = ACC_W'(LIMIT);
  localparam logic signed [ACC_W-1:0] LIM_LO  = ACC_W'(-LIMIT);
  localparam logic signed [ACC_W-1:0] DEAD_HI = ACC_W'(DEAD);
  localparam logic signed [ACC_W-1:0] DEAD_LO = ACC_W'(-DEAD);

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] avg;
  logic signed [ACC_W-1:0] scaled;
  logic signed [OUT_W-1:0] target;
  logic signed [OUT_W-1:0] target_calc;
  logic signed [OUT_W-1:0] out_next;

  always_comb begin
    avg         = sum >>> AVG_LOG2;
    scaled      = avg >>> SHIFT;
    target_calc = '0;
    if (scaled > LIM_HI)
      target_calc = LIM_HI[OUT_W-1:0];
    else if (scaled < LIM_LO)
      target_calc = LIM_LO[OUT_W-1:0];
    else if (scaled > DEAD_LO && scaled < DEAD_HI)
      target_calc = '0;
    else
      target_calc = scaled[OUT_W-1:0];
  end

`ifdef TILT_SLEW_EN
  localparam logic signed [OUT_W:0] SLEW_HI = (OUT_W+1)'(SLEW);
  localparam logic signed [OUT_W:0] SLEW_LO = (OUT_W+1)'(-SLEW);

  logic signed [OUT_W:0] diff;
  logic signed [OUT_W:0] step;

  // The step always moves toward the target, so the sum stays in range.
  always_comb begin
    diff = {target[OUT_W-1], target} - {sin_out[OUT_W-1], sin_out};
    step = diff;
    if (diff > SLEW_HI)
      step = SLEW_HI;
    else if (diff < SLEW_LO)
      step = SLEW_LO;
    out_next = sin_out + step[OUT_W-1:0];
  end
`else
  logic [31:0] unused_slew;
  assign unused_slew = 32'(SLEW);

  always_comb begin
    out_next = target;
  end
`endif

  assign changed = frame_start && (out_next != sin_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= '0;
      target  <= '0;
      sin_out <= '0;
    end else begin
      if (calc) begin
        sum    <= '0;
        target <= target_calc;
      end else if (accept) begin
        sum <= sum + ACC_W'(sample);
      end
      if (frame_start)
        sin_out <= out_next;
    end
  end

endmodule

// File: rtl/tilt_sin_filter.sv
// Tilt filter top: batch FSM and sample handshake driving two axis channels.
// Optional build macro TILT_SLEW_EN enables per-frame slew limiting of sin_x/sin_y.
module tilt_sin_filter
  import tilt_sin_pkg::*;
#(
  parameter int IN_W     = TILT_IN_W,
  parameter int OUT_W    = SIN_W,
  parameter int AVG_LOG2 = TILT_AVG_L2,
  parameter int DEAD     = TILT_DEAD,
  parameter int LIMIT    = TILT_LIMIT,
  parameter int SLEW     = TILT_SLEW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic signed [IN_W-1:0]  acc_x,
  input  logic signed [IN_W-1:0]  acc_y,
  input  logic                    frame_start,
  output logic signed [OUT_W-1:0] sin_x,
  output logic signed [OUT_W-1:0] sin_y,
  output logic                    upd
);

  localparam int COUNT_W = AVG_LOG2 + 1;
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'((1 << AVG_LOG2) - 1);

  tilt_state_t        state;
  tilt_state_t        state_next;
  logic [COUNT_W-1:0] count;
  logic               accept;
  logic               calc;
  logic               changed_x;
  logic               changed_y;

  always_ff @(posedge clk) begin
    if (rst)
      state <= ACC;
    else
      state <= state_next;
  end

  // Samples offered during CALC are dropped, not held back.
  always_comb begin
    state_next = state;
    acc_ready  = 1'b0;
    accept     = 1'b0;
    calc       = 1'b0;
    case (state)
      ACC: begin
        acc_ready = 1'b1;
        accept    = acc_valid;
        if (acc_valid && count == LAST)
          state_next = CALC;
      end
      CALC: begin
        calc       = 1'b1;
        state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (calc)
      count <= '0;
    else if (accept)
      count <= count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      upd <= 1'b0;
    else
      upd <= changed_x || changed_y;
  end

  tilt_axis_chan #(
    .IN_W(IN_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2),
    .DEAD(DEAD), .LIMIT(LIMIT), .SLEW(SLEW)
  ) u_chan_x (
    .clk(clk), .rst(rst), .sample(acc_x), .accept(accept), .calc(calc),
    .frame_start(frame_start), .sin_out(sin_x), .changed(changed_x)
  );

  tilt_axis_chan #(
    .IN_W(IN_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2),
    .DEAD(DEAD), .LIMIT(LIMIT), .SLEW(SLEW)
  ) u_chan_y (
    .clk(clk), .rst(rst), .sample(acc_y), .accept(accept), .calc(calc),
    .frame_start(frame_start), .sin_out(sin_y), .changed(changed_y)
  );

endmodule

// File: tb/tb_tilt_sin_filter.sv
// Self-checking bench for tilt_sin_filter: batch-level reference model plus directed literals.
module tb_tilt_sin_filter;
  import tilt_sin_pkg::*;

`ifdef TILT_SLEW_EN
  localparam bit SL = 1'b1;
`else
  localparam bit SL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              acc_valid = 1'b0;
  logic              acc_ready;
  logic signed [11:0] acc_x = '0;
  logic signed [11:0] acc_y = '0;
  logic              frame_start = 1'b0;
  logic signed [10:0] sin_x;
  logic signed [10:0] sin_y;
  logic              upd;

  always #5 clk = ~clk;

  tilt_sin_filter dut (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_x(acc_x), .acc_y(acc_y), .frame_start(frame_start),
    .sin_x(sin_x), .sin_y(sin_y), .upd(upd)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  int m_sx, m_sy, m_tx, m_ty, m_sumx, m_sumy, m_n, nx, ny;
  bit m_busy, m_upd;

  function automatic int floor_div(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Batch sum -> target: mean of 8, halved (2048 counts -> 1024), clamp, deadband.
  function automatic int to_target(int sum);
    int v;
    v = floor_div(floor_div(sum, 8), 2);
    if (v > 120) v = 120;
    if (v < -120) v = -120;
    if (v > -4 && v < 4) v = 0;
    return v;
  endfunction

  function automatic int step_toward(int o, int t);
    int d;
    d = t - o;
    if (SL) begin
      if (d > 8) d = 8;
      if (d < -8) d = -8;
    end
    return o + d;
  endfunction

  // Reference model: eight accepted samples form a batch, the following cycle is dead.
  always @(posedge clk) begin
    if (rst) begin
      m_sx = 0; m_sy = 0; m_tx = 0; m_ty = 0;
      m_sumx = 0; m_sumy = 0; m_n = 0; m_busy = 0; m_upd = 0;
    end else begin
      if (frame_start) begin
        nx = step_toward(m_sx, m_tx);
        ny = step_toward(m_sy, m_ty);
        m_upd = (nx != m_sx) || (ny != m_sy);
        m_sx = nx;
        m_sy = ny;
      end else begin
        m_upd = 0;
      end
      if (m_busy) begin
        m_tx = to_target(m_sumx);
        m_ty = to_target(m_sumy);
        m_sumx = 0; m_sumy = 0; m_n = 0; m_busy = 0;
      end else if (acc_valid) begin
        m_sumx += int'(acc_x);
        m_sumy += int'(acc_y);
        m_n++;
        if (m_n == 8) m_busy = 1;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("model_sin_x", int'(sin_x), m_sx);
      cmp("model_sin_y", int'(sin_y), m_sy);
      cmp("model_upd", int'(upd), int'(m_upd));
      cmp("model_acc_ready", int'(acc_ready), int'(!m_busy));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int x, input int y, input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!acc_ready && guard < 16) begin
        tick();
        guard++;
      end
      if (guard >= 16) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL ready_timeout: got acc_ready=0 for %0d cycles, expected 1", guard);
      end
      acc_valid = 1'b1;
      acc_x = 12'(x);
      acc_y = 12'(y);
      tick();
      acc_valid = 1'b0;
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int ex, input int ey, input int eu);
    cmp({name, "_sin_x"}, int'(sin_x), ex);
    cmp({name, "_sin_y"}, int'(sin_y), ey);
    cmp({name, "_upd"}, int'(upd), eu);
  endtask

  initial begin
    tick();
    started = 1'b1;
    rst = 1'b0;
    checkOutput("reset", 0, 0, 0);
    cmp("reset_acc_ready", int'(acc_ready), 1);

    // Steady tilt, slewed up to 100/-50.
    doReset();
    applyStimulus(200, -100, 8);
    tick();
    frame();
    checkOutput("t1_first", SL ? 8 : 100, SL ? -8 : -50, 1);
    repeat (13) frame();
    checkOutput("t1_settled", 100, -50, 0);

    // Small tilt inside the deadband.
    doReset();
    applyStimulus(-3, 6, 8);
    tick();
    frame();
    checkOutput("t2_dead", 0, 0, 0);

    // Full-scale tilt clamped to +/-120.
    doReset();
    applyStimulus(2047, -2048, 8);
    tick();
    frame();
    checkOutput("t3_first", SL ? 8 : 120, SL ? -8 : -120, 1);
    repeat (14) frame();
    checkOutput("t3_clamp", 120, -120, SL ? 1 : 0);

    // Continuous valid: one dead cycle per nine, the dead-slot value never counted.
    doReset();
    for (int k = 0; k < 18; k++) begin
      acc_valid = 1'b1;
      acc_x = (k % 9 == 8) ? 12'sd2000 : 12'sd16;
      acc_y = (k % 9 == 8) ? -12'sd2000 : -12'sd16;
      cmp("t4_ready", int'(acc_ready), (k % 9 == 8) ? 0 : 1);
      tick();
    end
    acc_valid = 1'b0;
    frame();
    checkOutput("t4_drop", 8, -8, 1);

    // frame_start in the CALC cycle uses the old target.
    doReset();
    applyStimulus(200, -100, 8);
    tick();
    frame();
    applyStimulus(40, 40, 8);
    cmp("t5_calc_ready", int'(acc_ready), 0);
    frame();
    checkOutput("t5_old_target", SL ? 16 : 100, SL ? -16 : -50, SL ? 1 : 0);
    frame();
    checkOutput("t5_new_target", 20, SL ? -8 : 20, 1);

    // Reset mid-batch discards the partial sums.
    doReset();
    applyStimulus(1000, 1000, 5);
    doReset();
    applyStimulus(100, -100, 8);
    tick();
    frame();
    checkOutput("t6_first", SL ? 8 : 50, SL ? -8 : -50, 1);
    repeat (6) frame();
    checkOutput("t6_settled", 50, -50, SL ? 1 : 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
